// File: rtl/adc_spi_sampler_if.sv
// Sample/SPI bundle between the ADC sampler (master) and its consumers (slave).
interface adc_spi_sampler_if;
  logic       en;
  logic [3:0] channel;
  logic       new_sample;
  logic [9:0] sample;
  logic [3:0] sample_channel;
  logic       spi_cs_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;

  modport master (
    input  en, channel, spi_miso,
    output new_sample, sample, sample_channel, spi_cs_n, spi_sck, spi_mosi
  );

  modport slave (
    output en, channel, spi_miso,
    input  new_sample, sample, sample_channel, spi_cs_n, spi_sck, spi_mosi
  );
endinterface

// File: rtl/adc_spi_sampler.sv
// Free-running SPI master for a 10-bit ADC. Each frame is 17 SCLK periods
// (mode 0). A one-cycle strobe publishes the result and its channel.
module adc_spi_sampler #(
  parameter int CLK_DIV     = 4,  // clk cycles per SCLK half-period
  parameter int IDLE_CYCLES = 8   // cs_n-high cycles in IDLE between frames
) (
  input  logic              clk,
  input  logic              rst,  // async, active low
  adc_spi_sampler_if.master bus
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_idle;
  logic [DW-1:0]   r_div;
  logic [4:0]      r_bit;      // current frame bit, 1..17
  logic [3:0]      r_ch_q;
  logic [9:0]      r_sr;
  logic            r_sck, r_cs_n, r_mosi, r_new_sample;
  logic [9:0]      r_sample;
  logic [3:0]      r_sample_ch;
  logic            w_half_end, w_idle_done, w_start, w_rise, w_fall;

  // Command word: start, single-ended, channel MSB first, then zeros.
  function automatic logic cmd_bit(input logic [4:0] k, input logic [3:0] ch);
    case (k)
      5'd1, 5'd2: cmd_bit = 1'b1;
      5'd3:       cmd_bit = ch[3];
      5'd4:       cmd_bit = ch[2];
      5'd5:       cmd_bit = ch[1];
      5'd6:       cmd_bit = ch[0];
      default:    cmd_bit = 1'b0;
    endcase
  endfunction

  // Next state plus the per-cycle events that drive the datapath.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_half_end  = (r_div == DW'(CLK_DIV - 1));
    w_idle_done = (r_idle == IW'(IDLE_CYCLES - 1));
    case (r_state)
      S_IDLE: if (w_idle_done && bus.en) begin
        w_start = 1'b1;
        w_next  = S_SHIFT;
      end
      S_SHIFT: if (w_half_end) begin
        if (!r_sck) w_rise = 1'b1;
        else begin
          w_fall = 1'b1;
          if (r_bit == 5'd17) w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle       <= '0;
      r_div        <= '0;
      r_bit        <= '0;
      r_ch_q       <= '0;
      r_sr         <= '0;
      r_sck        <= 1'b0;
      r_cs_n       <= 1'b1;
      r_mosi       <= 1'b0;
      r_new_sample <= 1'b0;
      r_sample     <= '0;
      r_sample_ch  <= '0;
    end else begin
      r_new_sample <= 1'b0;
      // idle count restarts whenever we leave IDLE; saturates while en=0
      if (r_state != S_IDLE)  r_idle <= '0;
      else if (!w_idle_done)  r_idle <= r_idle + IW'(1);
      if (r_state == S_SHIFT && !w_half_end) r_div <= r_div + DW'(1);
      else                                   r_div <= '0;
      if (w_start) begin
        r_ch_q <= bus.channel;
        r_cs_n <= 1'b0;
        r_mosi <= 1'b1;
        r_bit  <= 5'd1;
        r_sck  <= 1'b0;
      end
      if (w_rise) begin
        r_sck <= 1'b1;
        // bit 7 is the ADC null bit; data is bits 8..17
        if (r_bit >= 5'd8) r_sr <= {r_sr[8:0], bus.spi_miso};
      end
      if (w_fall) begin
        r_sck <= 1'b0;
        if (r_bit == 5'd17) begin
          r_cs_n       <= 1'b1;
          r_mosi       <= 1'b0;
          r_sample     <= r_sr;
          r_sample_ch  <= r_ch_q;
          r_new_sample <= 1'b1;
        end else begin
          r_bit  <= r_bit + 5'd1;
          r_mosi <= cmd_bit(r_bit + 5'd1, r_ch_q);
        end
      end
    end
  end

  assign bus.new_sample     = r_new_sample;
  assign bus.sample         = r_sample;
  assign bus.sample_channel = r_sample_ch;
  assign bus.spi_cs_n       = r_cs_n;
  assign bus.spi_sck        = r_sck;
  assign bus.spi_mosi       = r_mosi;
endmodule
